// File: rtl/video_timing_gen_pkg.sv
// Shared timing constants and helpers for the video timing generator.
// Defaults describe 1024x768 with a 1264x808 raster at a 51 MHz pixel clock.
package video_timing_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 48;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 96;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 33;

  function automatic int span_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
  } vtg_ctl_t;

  // Colour-bar palette, left to right
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_2ff.sv
// Two-flop synchronizer for a single slow asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async level through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, syncs, de, line/frame pulses.
// Optional colour-bar pattern on rgb when VTG_TEST_PATTERN_EN is defined.
// Pipeline: locked sync (2) -> counter arm (1) -> registered outputs (1).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [23:0]   rgb
);

  localparam int H_TOT = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [XW-1:0] H_LAST  = XW'(H_TOT - 1);
  localparam logic [XW-1:0] H_ACT_X = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOT - 1);
  localparam logic [YW-1:0] V_ACT_Y = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam vtg_ctl_t CTL_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0,
                                    line_start: 1'b0, frame_start: 1'b0};

  logic          locked_s;
  logic [0:0]    vld_pipe;   // counter holds a valid pixel position
  logic          act;
  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  vtg_ctl_t      ctl_d, ctl_q;

  sync_2ff u_lock_sync (
    .clk   (clk_pixel),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Output stage only runs once the counter has been armed for a cycle
  assign act = locked_s & vld_pipe[0];

  // Raster counters; held at origin while unlocked, arm one cycle after lock
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
    end else begin
      vld_pipe[0] <= locked_s;
      if (!locked_s) begin
        hcnt <= '0;
        vcnt <= '0;
      end else if (vld_pipe[0]) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  // Decode controls from the counter position; idle levels when not running
  always_comb begin
    ctl_d = CTL_IDLE;
    if (act) begin
      ctl_d.de          = (hcnt < H_ACT_X) && (vcnt < V_ACT_Y);
      ctl_d.hsync       = (hcnt >= HS_BEG && hcnt < HS_END) ? HS_POL : ~HS_POL;
      ctl_d.vsync       = (vcnt >= VS_BEG && vcnt < VS_END) ? VS_POL : ~VS_POL;
      ctl_d.line_start  = (hcnt == '0);
      ctl_d.frame_start = (hcnt == '0) && (vcnt == '0);
    end
  end

  // Register controls together with the x/y they describe
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= CTL_IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      ctl_q <= ctl_d;
      x     <= act ? hcnt : '0;
      y     <= act ? vcnt : '0;
    end
  end

  assign hsync       = ctl_q.hsync;
  assign vsync       = ctl_q.vsync;
  assign de          = ctl_q.de;
  assign line_start  = ctl_q.line_start;
  assign frame_start = ctl_q.frame_start;

`ifdef VTG_TEST_PATTERN_EN
  localparam int            BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [XW-1:0] BAR_W_X = XW'(BAR_W);

  logic [XW-1:0] bar;
  logic [23:0]   rgb_d;

  assign bar = hcnt / BAR_W_X;

  // Bar colour inside the visible area only, so rgb is blank whenever de is low
  always_comb begin
    rgb_d = '0;
    if (ctl_d.de) rgb_d = bar_color((bar > XW'(7)) ? 3'd7 : bar[2:0]);
  end

  // Pattern register, aligned with de
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) rgb <= '0;
    else        rgb <= rgb_d;
  end
`else
  assign rgb = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced 24x10 raster
// (16x6 visible, hsync x=18..20 active-high, vsync y=7..8 active-low).
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam bit HP = 1'b1, VP = 1'b0;
`ifdef VTG_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic        locked = 1'b0;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [10:0] x;
  logic [9:0]  y;
  logic [23:0] rgb;

  always #5 clk_pixel = ~clk_pixel;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .locked      (locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .rgb         (rgb)
  );

  // kind 0: pin vector, kind 1: window counts, kind 2: open count window
  typedef struct {
    int          cyc;
    int          kind;
    string       name;
    logic [10:0] x;
    logic [9:0]  y;
    logic        de, hs, vs, ls, fs;
    logic [23:0] rgb;
    int          n_de, n_ls, n_fs, n_vs, n_hs;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   c_de, c_ls, c_fs, c_vs, c_hs;
  bit   counting = 1'b0;
  exp_t e;

  function automatic logic [23:0] col(input logic [23:0] v);
    return PAT ? v : 24'h0;
  endfunction

  task automatic pix(input int c, input string nm, input int px, input int py,
                     input logic d, input logic h, input logic v,
                     input logic l, input logic f, input logic [23:0] c_rgb);
    exp_t t;
    t = '{cyc: c, kind: 0, name: nm, x: 11'(px), y: 10'(py), de: d, hs: h, vs: v,
          ls: l, fs: f, rgb: c_rgb, n_de: 0, n_ls: 0, n_fs: 0, n_vs: 0, n_hs: 0};
    q.push_back(t);
  endtask

  task automatic idle(input int c, input string nm);
    pix(c, nm, 0, 0, 1'b0, ~HP, ~VP, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic win(input int c, input int kind, input string nm,
                     input int nd, input int nl, input int nf, input int nv, input int nh);
    exp_t t;
    t = '{cyc: c, kind: kind, name: nm, x: '0, y: '0, de: 0, hs: 0, vs: 0, ls: 0, fs: 0,
          rgb: '0, n_de: nd, n_ls: nl, n_fs: nf, n_vs: nv, n_hs: nh};
    q.push_back(t);
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk_pixel); while (cyc < c);
  endtask

  always @(posedge clk_pixel) cyc <= cyc + 1;

  // Monitor: pop every expectation due this cycle and compare against the pins
  always @(negedge clk_pixel) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        $display("FAIL %s: expectation for cycle %0d not reached in order (now %0d)", e.name, e.cyc, cyc);
      end else if (e.kind == 0) begin
        if ({x, y, de, hsync, vsync, line_start, frame_start, rgb} ===
            {e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.rgb}) passed++;
        else
          $display("FAIL %s @%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h",
                   e.name, cyc, x, y, de, hsync, vsync, line_start, frame_start, rgb,
                   e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.rgb);
      end else if (e.kind == 1) begin
        if (c_de == e.n_de && c_ls == e.n_ls && c_fs == e.n_fs && c_vs == e.n_vs && c_hs == e.n_hs) passed++;
        else
          $display("FAIL %s: got de=%0d ls=%0d fs=%0d vs=%0d hs=%0d, want de=%0d ls=%0d fs=%0d vs=%0d hs=%0d",
                   e.name, c_de, c_ls, c_fs, c_vs, c_hs, e.n_de, e.n_ls, e.n_fs, e.n_vs, e.n_hs);
        counting = 1'b0;
      end else begin
        checks--;  // window opener is bookkeeping, not a comparison
        counting = 1'b1;
        c_de = 0; c_ls = 0; c_fs = 0; c_vs = 0; c_hs = 0;
      end
    end
    if (counting) begin
      c_de += int'(de);
      c_ls += int'(line_start);
      c_fs += int'(frame_start);
      c_vs += int'(vsync == VP);
      c_hs += int'(hsync == HP);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, r, z, t;
    idle(2, "reset_state");
    idle(3, "reset_held");
    wait_cyc(3);
    rst_n = 1'b1;
    idle(6, "unlocked_idle");
    idle(9, "unlocked_idle2");

    // Lock rises: sampled at edge cyc 11, first pixel after edge 14
    wait_cyc(10);
    locked = 1'b1;
    s = 14;
    idle(s - 1, "lock_edge2_idle");
    win(s, 2, "win_open", 0, 0, 0, 0, 0);
    pix(s + 0,   "first_pixel",     0,  0, 1, 0, 1, 1, 1, col(24'hFFFFFF));
    pix(s + 1,   "x1",              1,  0, 1, 0, 1, 0, 0, col(24'hFFFFFF));
    pix(s + 2,   "bar1",            2,  0, 1, 0, 1, 0, 0, col(24'hFFFF00));
    pix(s + 15,  "last_active_x",   15, 0, 1, 0, 1, 0, 0, col(24'h000000));
    pix(s + 16,  "first_blank_x",   16, 0, 0, 0, 1, 0, 0, 24'h0);
    pix(s + 17,  "hs_pre",          17, 0, 0, 0, 1, 0, 0, 24'h0);
    pix(s + 18,  "hs_on",           18, 0, 0, 1, 1, 0, 0, 24'h0);
    pix(s + 20,  "hs_last",         20, 0, 0, 1, 1, 0, 0, 24'h0);
    pix(s + 21,  "hs_off",          21, 0, 0, 0, 1, 0, 0, 24'h0);
    pix(s + 23,  "line_end",        23, 0, 0, 0, 1, 0, 0, 24'h0);
    pix(s + 24,  "line1",           0,  1, 1, 0, 1, 1, 0, col(24'hFFFFFF));
    pix(s + 135, "last_active_pix", 15, 5, 1, 0, 1, 0, 0, col(24'h000000));
    pix(s + 144, "first_blank_ln",  0,  6, 0, 0, 1, 1, 0, 24'h0);
    pix(s + 167, "vs_pre",          23, 6, 0, 0, 1, 0, 0, 24'h0);
    pix(s + 168, "vs_on",           0,  7, 0, 0, 0, 1, 0, 24'h0);
    pix(s + 215, "vs_last",         23, 8, 0, 0, 0, 0, 0, 24'h0);
    pix(s + 216, "vs_off",          0,  9, 0, 0, 1, 1, 0, 24'h0);
    pix(s + 239, "frame_end",       23, 9, 0, 0, 1, 0, 0, 24'h0);
    win(s + 240, 1, "frame_counts", 96, 10, 1, 48, 30);
    pix(s + 240, "frame2_start",    0,  0, 1, 0, 1, 1, 1, col(24'hFFFFFF));

    // Lock drops at frame-2 pixel x=10,y=3; two more pixels then idle
    d = s + 240 + 82;
    wait_cyc(d);
    locked = 1'b0;
    pix(d + 2, "drop_still_run", 12, 3, 1, 0, 1, 0, 0, col(24'h0000FF));
    idle(d + 3, "drop_idle");
    idle(d + 6, "drop_idle_hold");

    // Relock restarts from the origin with the same latency
    r = d + 10;
    wait_cyc(r);
    locked = 1'b1;
    idle(r + 3, "relock_edge2_idle");
    pix(r + 4, "relock_first", 0, 0, 1, 0, 1, 1, 1, col(24'hFFFFFF));
    pix(r + 5, "relock_x1",    1, 0, 1, 0, 1, 0, 0, col(24'hFFFFFF));
    z = r + 4 + 30;
    pix(z, "pre_reset_pix", 6, 1, 1, 0, 1, 0, 0, col(24'h00FF00));
    idle(z + 1, "async_reset");

    // Reset asserted between edges must act before the next edge
    wait_cyc(z);
    @(posedge clk_pixel);
    #2 rst_n = 1'b0;

    t = z + 3;
    wait_cyc(t);
    rst_n = 1'b1;
    idle(t + 3, "rst_rel_edge2_idle");
    pix(t + 4, "rst_rel_first", 0, 0, 1, 0, 1, 1, 1, col(24'hFFFFFF));

    wait_cyc(t + 8);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 48: horizontal front porch, pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync width, pixels.
REQ-004 SHALL have parameter H_BP, default 96: horizontal back porch, pixels (line total 1264).
REQ-005 SHALL have parameter V_ACTIVE, default 768: visible lines.
REQ-006 SHALL have parameter V_FP, default 3: vertical front porch, lines.
REQ-007 SHALL have parameter V_SYNC, default 4: vsync width, lines.
REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, lines (frame total 808).
REQ-009 SHALL have parameter HS_POL, default 1: active level of hsync.
REQ-010 SHALL have parameter VS_POL, default 1: active level of vsync.
REQ-011 SHALL have port clk_pixel, input, 1: 51 MHz pixel clock; sole clock.
REQ-012 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-013 SHALL have port locked, input, 1: PLL lock; asynchronous to clk_pixel.
REQ-014 SHALL have port hsync, output, 1: horizontal sync.
REQ-015 SHALL have port vsync, output, 1: vertical sync.
REQ-016 SHALL have port de, output, 1: data enable, high in the visible area.
REQ-017 SHALL have port x, output, 11: horizontal counter, 0..1263.
REQ-018 SHALL have port y, output, 10: vertical counter, 0..807.
REQ-019 SHALL have port line_start, output, 1: one-cycle pulse at x=0.
REQ-020 SHALL have port frame_start, output, 1: one-cycle pulse at x=0, y=0.
REQ-021 SHALL have port rgb, output, 24: test pattern {R,G,B}.

Function
REQ-022 SHALL pass locked through a two-flop synchronizer (locked_s) before any use.
REQ-023 SHALL hold x=0, y=0 and all outputs inactive while locked_s=0 (de=0, pulses 0, syncs at ~POL, rgb=0).
REQ-024 SHALL present x=0, y=0, de=1, line_start=1, frame_start=1 exactly 3 clk_pixel rising edges after locked is first sampled high.
REQ-025 SHALL increment x by one per cycle, wrapping 1263->0, and increment y on that wrap, wrapping 807->0.
REQ-026 SHALL compute every output as registered and cycle-aligned with the x/y values it describes.
REQ-027 SHALL assert de iff x<H_ACTIVE and y<V_ACTIVE.
REQ-028 SHALL drive hsync=HS_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (default 1072..1167).
REQ-029 SHALL drive vsync=VS_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (default 771..774), for whole lines.
REQ-030 SHALL, if locked_s falls mid-frame, force the REQ-023 state on the next edge and restart per REQ-024 after relock.
REQ-031 SHALL size counter arithmetic from parameter totals; no overflow of 11/10-bit widths for defaults.

Reset
REQ-032 SHALL on rst_n=0 asynchronously clear the synchronizer, set x=0, y=0, de=0, pulses=0, hsync=~HS_POL, vsync=~VS_POL, rgb=0.
REQ-033 SHALL treat rst_n release like locked_s=0: first pixel follows REQ-024 timing.

Configuration
REQ-034 SHALL with VTG_TEST_PATTERN_EN defined drive rgb with 8 vertical bars of H_ACTIVE/8 pixels: white, yellow, cyan, green, magenta, red, blue, black (full-scale 8-bit), rgb=0 when de=0, aligned with de.
REQ-035 SHALL without VTG_TEST_PATTERN_EN tie rgb to 0 and synthesize no pattern logic.

Structure
REQ-036 SHALL take default timing constants and H_TOTAL/V_TOTAL from shared package video_timing_pkg.
REQ-037 SHALL instantiate sub-module sync_2ff for the locked synchronizer.

Verification
REQ-038 SHALL check: locked rises at edge k -> de=1, x=0, y=0, frame_start=1 at edge k+3.
REQ-039 SHALL check: one full frame -> de high 1024x768=786432 cycles, 808 line_start pulses, one frame_start, period 1021312 cycles.
REQ-040 SHALL check: x=1071->1072 -> hsync goes to HS_POL; x=1167->1168 -> returns; y=771..774 -> vsync=VS_POL for 4x1264 cycles.
REQ-041 SHALL check: locked drops at x=500, y=300 -> 2 edges later outputs inactive, x=y=0; relock restarts per REQ-038.
REQ-042 SHALL check: rst_n low mid-line -> outputs reset immediately without a clock edge.
REQ-043 SHALL check with VTG_TEST_PATTERN_EN: x=0 -> rgb=FFFFFF, x=128 -> FFFF00, x=1023 -> 000000, x=1024 -> 000000 with de=0.
